bus_memory_responder: RTL and testbench

- Slave-side memory for the 8-bit RISC CPU bus: responds to the CPU's rd/wr strobes, 13-bit addr and bidirectional 8-bit data bus.
- Holds a program ROM region and a data RAM region.
- Reads complete after a programmable wait-state count; writes commit when the strobe falls.
- Provides a back-door preload port for program images, a ready indication, and a sticky bus-error flag.

---
 rtl/cpu_bus_pkg.sv | 23 ++
 rtl/bus_mem_array.sv | 41 ++++
 rtl/bus_memory_responder.sv | 154 +++++++++++++++
 tb/tb_bus_memory_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 8-bit RISC CPU bus: widths, memory map and
// the bus responder state encoding.
package cpu_bus_pkg;

  localparam int CPU_ADDR_W = 13;
  localparam int CPU_DATA_W = 8;
  localparam logic [CPU_ADDR_W-1:0] CPU_RAM_BASE = 13'h1800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_WR_ACTIVE,
    ST_CONFLICT
  } bus_state_e;

  // Everything below the RAM base is write-protected program ROM.
  function automatic logic is_rom(input logic [CPU_ADDR_W-1:0] a,
                                  input logic [CPU_ADDR_W-1:0] base);
    return a < base;
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Backing store for the whole bus address space: one write port shared by the
// bus commit and the back-door load, plus a registered read port.
module bus_mem_array #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_waddr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // A bus commit always wins the single write port over a back-door load.
  always_comb begin
    we    = bus_we_i | load_en_i;
    waddr = bus_we_i ? bus_waddr_i : load_addr_i;
    wdata = bus_we_i ? bus_wdata_i : load_data_i;
  end

  // NOTE: the array and its read register carry no reset, so they map onto
  // block RAM and keep their contents across a bus reset.
  always_ff @(posedge clk) begin
    if (we)   mem_q[waddr] <= wdata;
    if (re_i) rdata_q      <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_memory_responder.sv
// Slave-side ROM/RAM responder for the CPU bus: wait-stated reads, commit on
// write-strobe fall, back-door preload and a sticky bus-error flag.
module bus_memory_responder
  import cpu_bus_pkg::*;
#(
  parameter int                ADDR_W       = CPU_ADDR_W,
  parameter int                DATA_W       = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RAM_BASE     = CPU_RAM_BASE,
  parameter int                READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready,
  output logic              bus_err,
  input  logic              clr_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  bus_state_e        state_q, state_d;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] a_lat_q, a_lat_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bus_err_q, bus_err_d;
  logic              rd_rise, wr_fall, addr_moved;
  logic              commit, capture, err_set, drive_en;
  logic [DATA_W-1:0] rdata;

  assign rd_rise    = rd & ~rd_q;
  assign wr_fall    = ~wr & wr_q;
  assign addr_moved = addr != a_lat_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      a_lat_q   <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd;
      wr_q      <= wr;
      a_lat_q   <= a_lat_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_lat_d = a_lat_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    capture = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd && wr) begin
          state_d = ST_CONFLICT;
          err_set = 1'b1;
        end else if (rd_rise) begin
          a_lat_d = addr;
          cnt_d   = CNT_LOAD;
          state_d = ST_RD_WAIT;
        end else if (wr) begin
          a_lat_d = addr;
          state_d = ST_WR_ACTIVE;
        end
      end
      ST_RD_WAIT: begin
        if (!rd) begin
          state_d = ST_IDLE;
        end else if (addr_moved) begin
          a_lat_d = addr;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RD_DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_DRIVE: begin
        if (!rd) begin
          state_d = ST_IDLE;
        end else if (addr_moved) begin
          a_lat_d = addr;
          cnt_d   = CNT_LOAD;
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_ACTIVE: begin
        if (rd_rise) begin
          state_d = ST_CONFLICT;
          err_set = 1'b1;
        end else if (wr_fall) begin
          state_d = ST_IDLE;
          if (is_rom(a_lat_q, RAM_BASE)) err_set = 1'b1;
          else                           commit  = 1'b1;
        end
      end
      ST_CONFLICT: begin
        if (!rd && !wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drive_en = state_q == ST_RD_DRIVE;
    ready    = drive_en;
  end

  // The committed byte is the one present on the last cycle wr was high.
  assign wdata_d = wr ? data : wdata_q;

  // A new error (including a dropped back-door load) overrides clr_err.
  assign bus_err_d = err_set | (load_en & commit) | (bus_err_q & ~clr_err);
  assign bus_err   = bus_err_q;

  bus_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk         (clk),
    .bus_we_i    (commit),
    .bus_waddr_i (a_lat_q),
    .bus_wdata_i (wdata_q),
    .load_en_i   (load_en),
    .load_addr_i (load_addr),
    .load_data_i (load_data),
    .re_i        (capture),
    .raddr_i     (a_lat_q),
    .rdata_o     (rdata)
  );

  assign data = drive_en ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench for bus_memory_responder: vector table, directed corner
// sequences and randomized traffic against a flat memory model.
module tb_bus_memory_responder;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, clr_err, load_en;
  logic [12:0] addr, load_addr;
  logic [7:0]  load_data;
  logic        ready, bus_err;
  logic        tb_drv;
  logic [7:0]  tb_dout;
  wire  [7:0]  data;

  assign data = tb_drv ? tb_dout : 8'hzz;

  bus_memory_responder #(
    .ADDR_W       (13),
    .DATA_W       (8),
    .RAM_BASE     (13'h1800),
    .READ_LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .data      (data),
    .ready     (ready),
    .bus_err   (bus_err),
    .clr_err   (clr_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [0:8191];
  logic       err_m;

  typedef enum {T_LOAD, T_WRITE, T_READ, T_CLR} top_e;
  typedef struct {
    top_e        op;
    logic [12:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    logic        exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_nodrive(input string name);
    logic ok;
    total++;
    ok = $isunknown(data) ? (data === 8'hzz) : (data == 8'h00);
    if (!ok) begin
      bad++;
      $display("FAIL %s: bus shows %h expected high-Z", name, data);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [12:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic do_clr;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic do_write(input logic [12:0] a, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int beats);
    logic [7:0] last;
    addr = a; wr = 1'b1; tb_drv = 1'b1;
    for (int i = 0; i < beats; i++) begin
      tb_dout = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      last = tb_dout;
      tick;
    end
    wr = 1'b0; tb_drv = 1'b0;
    tick;
    if (a < 13'h1800) err_m = 1'b1;
    else              mem_m[a] = last;
  endtask

  task automatic wait_ready(inout int n);
    while (!ready && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic do_read(input logic [12:0] a, input logic [7:0] exp, input string tag);
    int n;
    addr = a; rd = 1'b1;
    tick;
    n = 1;
    wait_ready(n);
    check({tag, " latency"}, n, L + 1);
    check({tag, " data"}, data, exp);
    rd = 1'b0;
    tick;
    check({tag, " ready drop"}, ready, 1'b0);
    check_nodrive({tag, " release"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [12:0] ra;
    int k;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; clr_err = 1'b0; load_en = 1'b0;
    addr = '0; load_addr = '0; load_data = '0; tb_drv = 1'b0; tb_dout = '0;
    err_m = 1'b0;
    tick; tick;
    check("reset ready", ready, 1'b0);
    check("reset bus_err", bus_err, 1'b0);
    check_nodrive("reset bus");
    rst = 1'b0;
    tick;

    tbl[0]  = '{T_LOAD,  13'h0005, 8'hA7, 8'h00, 1'b0};
    tbl[1]  = '{T_READ,  13'h0005, 8'h00, 8'hA7, 1'b0};
    tbl[2]  = '{T_LOAD,  13'h17FF, 8'hC4, 8'h00, 1'b0};
    tbl[3]  = '{T_WRITE, 13'h17FF, 8'h33, 8'h00, 1'b1};
    tbl[4]  = '{T_READ,  13'h17FF, 8'h00, 8'hC4, 1'b1};
    tbl[5]  = '{T_CLR,   13'h0000, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{T_WRITE, 13'h1800, 8'h5D, 8'h00, 1'b0};
    tbl[7]  = '{T_READ,  13'h1800, 8'h00, 8'h5D, 1'b0};
    tbl[8]  = '{T_WRITE, 13'h1FFF, 8'hE2, 8'h00, 1'b0};
    tbl[9]  = '{T_READ,  13'h1FFF, 8'h00, 8'hE2, 1'b0};
    tbl[10] = '{T_LOAD,  13'h0000, 8'h3B, 8'h00, 1'b0};
    tbl[11] = '{T_READ,  13'h0000, 8'h00, 8'h3B, 1'b0};

    for (int i = 0; i < 12; i++) begin
      case (tbl[i].op)
        T_LOAD:  do_load(tbl[i].a, tbl[i].d);
        T_WRITE: do_write(tbl[i].a, tbl[i].d, tbl[i].d, tbl[i].d, 1);
        T_READ:  do_read(tbl[i].a, tbl[i].exp_d, $sformatf("vec%0d", i));
        default: do_clr;
      endcase
      check($sformatf("vec%0d bus_err", i), bus_err, tbl[i].exp_err);
    end

    // Multi-beat write: last beat is the one committed.
    do_write(13'h1803, 8'h11, 8'h22, 8'h3C, 3);
    do_read(13'h1803, 8'h3C, "multibeat");
    check("multibeat bus_err", bus_err, 1'b0);

    // ROM write protection, then clear.
    do_load(13'h0010, 8'h9E);
    do_write(13'h0010, 8'h55, 8'h55, 8'h55, 1);
    check("rom write err", bus_err, 1'b1);
    do_read(13'h0010, 8'h9E, "rom readback");
    do_clr;
    check("clr_err", bus_err, 1'b0);

    // Error set in the same cycle as clr_err: set wins.
    addr = 13'h0020; wr = 1'b1; tb_drv = 1'b1; tb_dout = 8'h01;
    tick;
    wr = 1'b0; tb_drv = 1'b0; clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("set beats clear", bus_err, 1'b1);
    do_clr;

    // rd and wr together from IDLE.
    do_load(13'h1900, 8'h5A);
    addr = 13'h1900; rd = 1'b1; wr = 1'b1;
    tick;
    check("conflict ready", ready, 1'b0);
    check_nodrive("conflict bus");
    check("conflict err", bus_err, 1'b1);
    tick;
    check("conflict hold ready", ready, 1'b0);
    rd = 1'b0; wr = 1'b0;
    tick;
    do_clr;
    do_read(13'h1900, 8'h5A, "conflict nowrite");

    // rd rising during an active write aborts the commit.
    do_load(13'h1905, 8'h12);
    addr = 13'h1905; wr = 1'b1; tb_drv = 1'b1; tb_dout = 8'h44;
    tick;
    rd = 1'b1;
    tick;
    check("wr-rd conflict err", bus_err, 1'b1);
    rd = 1'b0; wr = 1'b0; tb_drv = 1'b0;
    tick;
    do_clr;
    do_read(13'h1905, 8'h12, "wr-rd nocommit");

    // Address change while driving restarts the read.
    do_load(13'h1800, 8'h61);
    do_load(13'h1801, 8'h62);
    addr = 13'h1800; rd = 1'b1;
    tick;
    n = 1;
    wait_ready(n);
    check("restart first data", data, 8'h61);
    addr = 13'h1801;
    tick;
    check("restart ready drop", ready, 1'b0);
    n = 1;
    wait_ready(n);
    check("restart latency", n, L + 1);
    check("restart data", data, 8'h62);
    rd = 1'b0;
    tick;
    check("restart end ready", ready, 1'b0);

    // Back-door load during the wait is seen by the pending read.
    do_load(13'h1830, 8'h01);
    addr = 13'h1830; rd = 1'b1;
    tick;
    do_load(13'h1830, 8'h02);
    n = 2;
    wait_ready(n);
    check("load in wait latency", n, L + 1);
    check("load in wait data", data, 8'h02);
    rd = 1'b0;
    tick;

    // Load colliding with a bus commit is dropped and flagged.
    do_load(13'h1820, 8'h10);
    addr = 13'h1810; wr = 1'b1; tb_drv = 1'b1; tb_dout = 8'h77;
    tick;
    wr = 1'b0; tb_drv = 1'b0;
    load_en = 1'b1; load_addr = 13'h1820; load_data = 8'h99;
    tick;
    load_en = 1'b0;
    mem_m[13'h1810] = 8'h77;
    check("collision err", bus_err, 1'b1);
    do_read(13'h1820, 8'h10, "collision dropped");
    do_read(13'h1810, 8'h77, "collision commit");
    do_clr;

    // Reset in the middle of a driven read.
    addr = 13'h1803; rd = 1'b1;
    tick;
    n = 1;
    wait_ready(n);
    check("pre-reset ready", ready, 1'b1);
    rst = 1'b1;
    #1;
    check("async reset ready", ready, 1'b0);
    check_nodrive("async reset bus");
    rd = 1'b0;
    tick; tick;
    rst = 1'b0;
    err_m = 1'b0;
    tick;
    check("post reset err", bus_err, 1'b0);
    do_read(13'h1803, 8'h3C, "ram survives reset");

    // Randomized traffic around the ROM/RAM boundary.
    for (int j = 0; j < 16; j++) do_load(13'h17F8 + 13'(j), 8'($urandom));
    for (int i = 0; i < 50; i++) begin
      ra = 13'h17F8 + 13'($urandom_range(0, 15));
      k  = $urandom_range(0, 3);
      case (k)
        0:       do_load(ra, 8'($urandom));
        1, 2:    do_write(ra, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3));
        default: do_read(ra, mem_m[ra], $sformatf("rnd%0d", i));
      endcase
      check($sformatf("rnd%0d bus_err", i), bus_err, err_m);
      if (err_m) do_clr;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
